// File: rtl/scorecnt_pkg.sv
// Shared constants and count type for the scoreboard score counter.
package scorecnt_pkg;

    localparam int unsigned SCORE_BW          = 7;
    localparam int unsigned SCORE_MAX         = 99;
    localparam int unsigned SCORE_SYNC_STAGES = 2;

    typedef logic [SCORE_BW-1:0] score_t;

endpackage

// File: rtl/scorecnt_edge_sync.sv
// Single-bit synchroniser followed by a rising-edge detector.
module scorecnt_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // prev_q resets low, so a button held through reset yields one event afterwards
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/scoreboard_counter.sv
// Multi-channel up/down score counter bounded to 0..MAX_VAL.
// Define SCORECNT_WRAP_EN to wrap at the bounds instead of saturating.
module scoreboard_counter
    import scorecnt_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned BW          = SCORE_BW,
    parameter int unsigned MAX_VAL     = SCORE_MAX,
    parameter int unsigned SYNC_STAGES = SCORE_SYNC_STAGES
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_CH-1:0]    up_i,
    input  logic [NUM_CH-1:0]    down_i,
    input  logic                 clr_i,
    output logic [NUM_CH*BW-1:0] cnt_o,
    output logic [NUM_CH-1:0]    max_o,
    output logic [NUM_CH-1:0]    changed_o
);

    localparam logic [BW-1:0] MaxVal = BW'(MAX_VAL);

    logic [NUM_CH-1:0] up_rise;
    logic [NUM_CH-1:0] dn_rise;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [BW-1:0] cnt_q, cnt_d;
        logic          max_q, chg_q;

        scorecnt_edge_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_up_sync (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    (up_i[c]),
            .rise_o (up_rise[c])
        );

        scorecnt_edge_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_dn_sync (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    (down_i[c]),
            .rise_o (dn_rise[c])
        );

        always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
                cnt_d = '0;
            end else if (up_rise[c] && !dn_rise[c]) begin
                if (cnt_q < MaxVal) begin
                    cnt_d = cnt_q + BW'(1);
                end else begin
`ifdef SCORECNT_WRAP_EN
                    cnt_d = '0;
`else
                    cnt_d = cnt_q;
`endif
                end
            end else if (dn_rise[c] && !up_rise[c]) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - BW'(1);
                end else begin
`ifdef SCORECNT_WRAP_EN
                    cnt_d = MaxVal;
`else
                    cnt_d = cnt_q;
`endif
                end
            end
        end

        // Flags are registered alongside the count so all outputs move on the same edge
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
                max_q <= 1'b0;
                chg_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                max_q <= (cnt_d == MaxVal);
                chg_q <= (cnt_d != cnt_q);
            end
        end

        assign cnt_o[c*BW +: BW] = cnt_q;
        assign max_o[c]          = max_q;
        assign changed_o[c]      = chg_q;
    end

endmodule

// File: tb/tb_scoreboard_counter.sv
// Self-checking bench for scoreboard_counter; honours SCORECNT_WRAP_EN when defined.
module tb_scoreboard_counter;
    import scorecnt_pkg::*;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned BW     = 7;
    localparam int unsigned MAXV   = 99;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic [NUM_CH-1:0]    up_i;
    logic [NUM_CH-1:0]    down_i;
    logic                 clr_i;
    logic [NUM_CH*BW-1:0] cnt_o;
    logic [NUM_CH-1:0]    max_o;
    logic [NUM_CH-1:0]    changed_o;

    scoreboard_counter #(
        .NUM_CH      (NUM_CH),
        .BW          (BW),
        .MAX_VAL     (MAXV),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .up_i      (up_i),
        .down_i    (down_i),
        .clr_i     (clr_i),
        .cnt_o     (cnt_o),
        .max_o     (max_o),
        .changed_o (changed_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] up;
        logic [1:0] dn;
        logic       clr;
        score_t     e0;
        score_t     e1;
        int         c0;
        int         c1;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   chg0  = 0;
    int   chg1  = 0;

    function automatic void add(logic [1:0] up, logic [1:0] dn, logic clr,
                                int e0, int e1, int c0, int c1);
        vec_t v;
        v.up  = up;
        v.dn  = dn;
        v.clr = clr;
        v.e0  = score_t'(e0);
        v.e1  = score_t'(e1);
        v.c0  = c0;
        v.c1  = c1;
        vecs.push_back(v);
    endfunction

    function automatic logic [BW-1:0] ch(int c);
        return cnt_o[c*BW +: BW];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Advance one clock and sample just after the edge, tallying changed_o pulses
    task automatic step();
        @(posedge clk);
        #1;
        if (changed_o[0] === 1'b1) chg0++;
        if (changed_o[1] === 1'b1) chg1++;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_pulses();
        chg0 = 0;
        chg1 = 0;
    endtask

    initial begin
        rst_ni = 1'b0;
        up_i   = '0;
        down_i = '0;
        clr_i  = 1'b0;

        // Reset with buttons toggling
        for (int i = 0; i < 6; i++) begin
            #10;
            up_i   = up_i ^ 2'b11;
            down_i = down_i ^ 2'b01;
        end
        chk("reset_cnt", 32'(cnt_o), 32'd0);
        chk("reset_max", 32'(max_o), 32'd0);
        chk("reset_chg", 32'(changed_o), 32'd0);

        // Release with up_i[0] held: exactly one event
        @(posedge clk);
        #1;
        up_i   = 2'b01;
        down_i = 2'b00;
        clr_pulses();
        rst_ni = 1'b1;
        steps(6);
        chk("held_rel_cnt0", 32'(ch(0)), 32'd1);
        chk("held_rel_cnt1", 32'(ch(1)), 32'd0);
        steps(4);
        chk("held_once_cnt0", 32'(ch(0)), 32'd1);
        chk("held_once_pulses", 32'(chg0), 32'd1);
        up_i = 2'b00;
        steps(4);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        chk("clr_after_reset", 32'(ch(0)), 32'd0);
        steps(2);

        // Latency: first sample at edge k, update at edge k+2, one-cycle pulse
        for (int i = 1; i <= 5; i++) begin
            up_i[0] = 1'b1;
            step();
            chk("lat_k", 32'(ch(0)), 32'(i - 1));
            step();
            chk("lat_k1", 32'(ch(0)), 32'(i - 1));
            chk("lat_k1_chg", 32'(changed_o), 32'd0);
            step();
            chk("lat_k2", 32'(ch(0)), 32'(i));
            chk("lat_k2_chg", 32'(changed_o), 32'b01);
            step();
            chk("lat_k3_chg", 32'(changed_o), 32'd0);
            step();
            up_i[0] = 1'b0;
            steps(5);
        end
        chk("lat_final0", 32'(ch(0)), 32'd5);
        chk("lat_final1", 32'(ch(1)), 32'd0);

        // Table of single presses starting from (5, 0)
        add(2'b00, 2'b00, 1'b1, 0, 0, 1, 0);
`ifdef SCORECNT_WRAP_EN
        add(2'b00, 2'b01, 1'b0, 99, 0, 1, 0);
        add(2'b00, 2'b01, 1'b0, 98, 0, 1, 0);
        add(2'b00, 2'b00, 1'b1, 0, 0, 1, 0);
`else
        add(2'b00, 2'b01, 1'b0, 0, 0, 0, 0);
        add(2'b00, 2'b01, 1'b0, 0, 0, 0, 0);
        add(2'b00, 2'b00, 1'b1, 0, 0, 0, 0);
`endif
        for (int i = 1; i <= 4; i++) add(2'b11, 2'b00, 1'b0, i, i, 1, 1);
        for (int i = 5; i <= 10; i++) add(2'b01, 2'b00, 1'b0, i, 4, 1, 0);
        add(2'b01, 2'b01, 1'b0, 10, 4, 0, 0);
        add(2'b01, 2'b10, 1'b0, 11, 3, 1, 1);
        for (int i = 4; i <= 99; i++) add(2'b10, 2'b00, 1'b0, 11, i, 0, 1);
`ifdef SCORECNT_WRAP_EN
        for (int i = 0; i <= 2; i++) add(2'b10, 2'b00, 1'b0, 11, i, 0, 1);
`else
        for (int i = 0; i <= 2; i++) add(2'b10, 2'b00, 1'b0, 11, 99, 0, 0);
`endif
        add(2'b00, 2'b00, 1'b1, 0, 0, 1, 1);
        for (int i = 1; i <= 7; i++) add(2'b11, 2'b00, 1'b0, i, i, 1, 1);
        for (int i = 8; i <= 42; i++) add(2'b01, 2'b00, 1'b0, i, 7, 1, 0);

        for (int v = 0; v < vecs.size(); v++) begin
            clr_pulses();
            up_i   = vecs[v].up;
            down_i = vecs[v].dn;
            clr_i  = vecs[v].clr;
            step();
            clr_i = 1'b0;
            steps(3);
            up_i   = '0;
            down_i = '0;
            steps(4);
            chk($sformatf("vec%0d_cnt0", v), 32'(ch(0)), 32'(vecs[v].e0));
            chk($sformatf("vec%0d_cnt1", v), 32'(ch(1)), 32'(vecs[v].e1));
            chk($sformatf("vec%0d_chg0", v), 32'(chg0), 32'(vecs[v].c0));
            chk($sformatf("vec%0d_chg1", v), 32'(chg1), 32'(vecs[v].c1));
            chk($sformatf("vec%0d_max", v), 32'(max_o),
                32'({vecs[v].e1 == score_t'(MAXV), vecs[v].e0 == score_t'(MAXV)}));
        end

        // Clear coincident with a ch0 up event at (42, 7)
        up_i[0] = 1'b1;
        steps(2);
        clr_i = 1'b1;
        step();
        chk("clr_cnt0", 32'(ch(0)), 32'd0);
        chk("clr_cnt1", 32'(ch(1)), 32'd0);
        chk("clr_chg", 32'(changed_o), 32'b11);
        clr_i = 1'b0;
        step();
        chk("clr_discard_cnt0", 32'(ch(0)), 32'd0);
        chk("clr_discard_chg", 32'(changed_o), 32'd0);
        up_i[0] = 1'b0;
        steps(4);

        // Asynchronous reset mid-count, checked before the next clock edge
        up_i = 2'b11;
        steps(4);
        up_i = 2'b00;
        steps(4);
        chk("pre_async_cnt", 32'(cnt_o), 32'({7'd1, 7'd1}));
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_cnt", 32'(cnt_o), 32'd0);
        chk("async_max", 32'(max_o), 32'd0);
        chk("async_chg", 32'(changed_o), 32'd0);
        #20;
        rst_ni = 1'b1;
        steps(4);
        chk("post_async_cnt", 32'(cnt_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
